conv_out_collector: RTL and testbench
=====================================

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 Parameter W, 20, signed width of each MAC lane result.
REQ-002 Parameter SHIFT, 4, arithmetic right-shift (fixed-point rescale) applied to each lane.
REQ-003 Parameter TOTAL, 64, output pixels per layer run; multiple of 4.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rstN  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle pulse; begins (or restarts) a layer run.
REQ-007 Port inValid  input  1  four MAC lane results present on mac0..mac3.
REQ-008 Port inReady  output  1  block can accept a lane group this cycle.
REQ-009 Port mac0, mac1, mac2, mac3  input  W each  signed MAC results from the four parallel datapaths.
REQ-010 Port outValid  output  1  outData holds a valid pixel.
REQ-011 Port outReady  input  1  downstream accepts outData this cycle.
REQ-012 Port outData  output  8  unsigned activated pixel.
REQ-013 Port outIdx  output  12  linear index (0..TOTAL-1) of the current outData pixel.
REQ-014 Port done  output  1  run complete; held until next start or reset.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, SERIAL, DONE.
REQ-016 IDLE: inReady=0, outValid=0; start -> COLLECT, pixel counter cleared to 0.
REQ-017 COLLECT: inReady=1; inValid&&inReady captures all four lanes into lane registers -> SERIAL next cycle.
REQ-018 Per-lane activation at capture: v<0 -> 0; else s=v>>>SHIFT; s>255 -> 255; else s[7:0].
REQ-019 Latency: capture at cycle n -> outValid=1 with lane 0 at cycle n+1.
REQ-020 SERIAL: outValid=1, outData = activated lane[laneSel], laneSel starting at 0; outIdx = pixel counter.
REQ-021 Transfer occurs on outValid&&outReady; laneSel and pixel counter increment by 1.
REQ-022 outReady=0 SHALL hold outData, outIdx, outValid stable (no drop, no duplicate).
REQ-023 Transfer of lane 3: counter==TOTAL-1 -> DONE; else -> COLLECT.
REQ-024 inReady SHALL be 0 in SERIAL; inValid outside COLLECT is ignored (no capture).
REQ-025 DONE: done=1, inReady=0, outValid=0; start -> COLLECT with counter cleared, done=0 next cycle.
REQ-026 start in COLLECT or SERIAL SHALL abort the run: lane data discarded, counter=0, laneSel=0, state COLLECT next cycle.
REQ-027 start takes priority over a simultaneous inValid capture or outReady transfer.
REQ-028 Pixel counter 12 bits; never exceeds TOTAL-1; no wrap during a run.

Reset
REQ-029 rstN=0 SHALL asynchronously force state IDLE, counter=0, laneSel=0, lane registers=0.
REQ-030 During and after reset until start: inReady=0, outValid=0, outData=0, outIdx=0, done=0.
REQ-031 Reset mid-run discards all pending lanes; no outValid after release without a new start.

Verification
REQ-032 Reset then start, mac0..3 = 16, 32, 4095, -5 with inValid, outReady=1 -> outData 1, 2, 255, 0 on consecutive cycles, outIdx 0..3, first outValid one cycle after capture.
REQ-033 Lane group with mac0=4096 (SHIFT=4) -> 256 saturates to 255; mac1=15 -> 0; mac2=-1 -> 0.
REQ-034 outReady toggled 0/1 each cycle during SERIAL -> each of 4 pixels emitted exactly once, data stable while stalled, inReady=0 throughout.
REQ-035 Full run TOTAL=64 (16 groups) with random inValid gaps -> 64 transfers, outIdx 0..63 in order, done=1 after 64th transfer and held; further inValid ignored.
REQ-036 start asserted after 2nd lane of group 5 transferred -> counter 0, next capture emits outIdx 0; start coincident with inValid -> capture ignored.
REQ-037 rstN low during SERIAL -> outValid=0, inReady=0, done=0 immediately (asynchronous); no output until next start.

Source files
------------

// File: rtl/conv_out_collector.sv
// Collects four MAC lane results per group, applies a shift/ReLU/saturate activation,
// and serialises the activated pixels one per transfer with a running pixel index.
module conv_lane_act #(
  parameter int W     = 20,
  parameter int SHIFT = 4
) (
  input  logic signed [W-1:0] v,
  output logic        [7:0]   a
);
  logic [W-1:0] s;

  assign s = v >>> SHIFT;

  always_comb begin
    a = 8'd0;
    if (v[W-1])      a = 8'd0;
    else if (|s[W-1:8]) a = 8'hFF;
    else             a = s[7:0];
  end
endmodule

module conv_out_collector #(
  parameter int W     = 20,
  parameter int SHIFT = 4,
  parameter int TOTAL = 64
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                inValid,
  output logic                inReady,
  input  logic signed [W-1:0] mac0,
  input  logic signed [W-1:0] mac1,
  input  logic signed [W-1:0] mac2,
  input  logic signed [W-1:0] mac3,
  output logic                outValid,
  input  logic                outReady,
  output logic [7:0]          outData,
  output logic [11:0]         outIdx,
  output logic                done
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, COLLECT, SERIAL, DONE} state_t;

  state_t                            state;
  logic [NUM_LANES-1:0][W-1:0]       macs;
  logic [NUM_LANES-1:0][7:0]         act;
  logic [NUM_LANES-1:0][7:0]         lane;
  logic [1:0]                        lane_sel;
  logic [11:0]                       cnt;

  assign macs = {mac3, mac2, mac1, mac0};

  // Activation happens on the way into the lane registers, so only 8 bits per lane are held.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    conv_lane_act #(.W(W), .SHIFT(SHIFT)) u_act (
      .v (macs[g]),
      .a (act[g])
    );
  end

  assign outData = outValid ? lane[lane_sel] : 8'd0;
  assign outIdx  = cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      cnt      <= '0;
      lane_sel <= '0;
      lane     <= '0;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      // start wins over any capture or transfer in the same cycle
      state    <= COLLECT;
      cnt      <= '0;
      lane_sel <= '0;
      lane     <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (inValid) begin
          lane     <= act;
          lane_sel <= '0;
          state    <= SERIAL;
          inReady  <= 1'b0;
          outValid <= 1'b1;
        end
        SERIAL: if (outReady) begin
          lane_sel <= lane_sel + 2'd1;
          if (lane_sel == 2'd3) begin
            outValid <= 1'b0;
            if (cnt == 12'(TOTAL - 1)) begin
              // counter parks on the last index rather than wrapping
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= COLLECT;
              cnt     <= cnt + 12'd1;
              inReady <= 1'b1;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: expected pixels are queued at issue time and
// checked by an independent monitor whenever a transfer is presented.
module tb_conv_out_collector;
  localparam int W = 20;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                start = 1'b0;
  logic                inValid = 1'b0;
  logic                outReady = 1'b0;
  logic signed [W-1:0] mac0 = '0, mac1 = '0, mac2 = '0, mac3 = '0;
  logic                inReady, outValid, done;
  logic [7:0]          outData;
  logic [11:0]         outIdx;

  typedef struct packed {
    logic [7:0]  d;
    logic [11:0] i;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   mode   = 0;

  conv_out_collector #(.W(W), .SHIFT(4), .TOTAL(64)) dut (
    .clk(clk), .rstN(rstN), .start(start), .inValid(inValid), .inReady(inReady),
    .mac0(mac0), .mac1(mac1), .mac2(mac2), .mac3(mac3),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outIdx(outIdx),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // outReady pattern: 0 always ready, 1 toggle, 2 random, 3 stalled
  initial forever begin
    @(posedge clk); #1;
    case (mode)
      0: outReady = 1'b1;
      1: outReady = !outReady;
      2: outReady = 1'($urandom_range(0, 1));
      default: outReady = 1'b0;
    endcase
  end

  // Monitor: pops on every real transfer, checks stall stability and inReady low while serialising
  initial begin
    logic       held;
    logic [7:0] hd;
    logic [11:0] hi;
    exp_t       e;
    held = 1'b0; hd = '0; hi = '0;
    forever begin
      @(negedge clk);
      if (!rstN) held = 1'b0;
      else begin
        if (held) chk("stall_hold", {outValid, outData, outIdx}, {1'b1, hd, hi});
        held = 1'b0;
        if (outValid) chk("in_ready_in_serial", inReady, 0);
        if (outValid && outReady && !start) begin
          if (q.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL unexpected_out: got data %0d idx %0d, expected no transfer", outData, outIdx);
          end else begin
            e = q.pop_front();
            chk("out_data", outData, e.d);
            chk("out_idx", outIdx, e.i);
          end
        end else if (outValid && !start) begin
          held = 1'b1; hd = outData; hi = outIdx;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue one lane group; n of the four expected pixels are queued (n<4 when a run is aborted).
  task automatic send(input int a, input int b, input int c, input int d,
                      input int e0, input int e1, input int e2, input int e3,
                      input int idx0, input int n);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    for (int k = 0; k < 200; k++) begin
      if (inReady) break;
      @(posedge clk); #1;
    end
    chk("in_ready_wait", inReady, 1);
    mac0 = W'(a); mac1 = W'(b); mac2 = W'(c); mac3 = W'(d);
    inValid = 1'b1;
    for (int k = 0; k < n; k++) q.push_back({8'(ex[k]), 12'(idx0 + k)});
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int p;
    bit hit;
    #12;
    chk("rst_in_ready", inReady, 0);
    chk("rst_out_valid", outValid, 0);
    chk("rst_out_data", outData, 0);
    chk("rst_out_idx", outIdx, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_out_valid", outValid, 0);
    chk("idle_in_ready", inReady, 0);

    // basic group, then inValid held into SERIAL must be ignored
    mode = 0;
    pulse_start();
    chk("start_in_ready", inReady, 1);
    chk("start_done", done, 0);
    send(16, 32, 4095, -5, 1, 2, 255, 0, 0, 4);
    chk("lat_valid", outValid, 1);
    chk("lat_idx", outIdx, 0);
    chk("lat_data", outData, 1);
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    wait_drain();

    // saturation / negative / truncation under toggling outReady
    mode = 1;
    send(4096, 15, -1, 160, 255, 0, 0, 10, 4, 4);
    wait_drain();
    chk("collect_in_ready", inReady, 1);

    // full 64-pixel run with random gaps and random backpressure
    mode = 2;
    pulse_start();
    for (int g = 0; g < 16; g++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      p = g * 4;
      if (g % 4 == 3)
        send(p*16+7, -((p+1)*16), (p+2)*16+7, (p+3)*16, p, 0, p+2, p+3, p, 4);
      else
        send(p*16+7, (p+1)*16+15, (p+2)*16, (p+3)*16+1, p, p+1, p+2, p+3, p, 4);
    end
    wait_drain();
    chk("run_done", done, 1);
    chk("run_out_valid", outValid, 0);
    chk("run_in_ready", inReady, 0);
    chk("run_last_idx", outIdx, 63);
    mode = 0;
    mac0 = 20'sd4000; inValid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    inValid = 1'b0;
    chk("done_held", done, 1);
    chk("done_no_out", outValid, 0);

    // abort after second lane of group 5
    pulse_start();
    chk("restart_done_clr", done, 0);
    for (int g = 0; g < 5; g++) begin
      p = g * 4;
      send(p*16, (p+1)*16, (p+2)*16, (p+3)*16, p, p+1, p+2, p+3, p, 4);
    end
    send(20*16+3, 21*16+3, 22*16+3, 23*16+3, 20, 21, 22, 23, 20, 2);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (outValid && outReady && outIdx == 12'd21) begin hit = 1'b1; break; end
    end
    chk("abort_reach_idx21", int'(hit), 1);
    @(posedge clk); #1;
    start = 1'b1; inValid = 1'b1; mac0 = 20'sd999;
    @(posedge clk); #1;
    start = 1'b0; inValid = 1'b0;
    chk("abort_idx", outIdx, 0);
    chk("abort_out_valid", outValid, 0);
    chk("abort_in_ready", inReady, 1);
    start = 1'b1; inValid = 1'b1; mac0 = 20'sd160;
    @(posedge clk); #1;
    start = 1'b0; inValid = 1'b0;
    chk("co_out_valid", outValid, 0);
    chk("co_in_ready", inReady, 1);
    send(64, 80, 96, 112, 4, 5, 6, 7, 0, 4);
    wait_drain();

    // asynchronous reset while stalled in SERIAL
    mode = 3;
    @(posedge clk); #1;
    send(48, 64, 80, 96, 3, 4, 5, 6, 4, 4);
    chk("pre_rst_valid", outValid, 1);
    #2 rstN = 1'b0;
    #1;
    chk("arst_out_valid", outValid, 0);
    chk("arst_in_ready", inReady, 0);
    chk("arst_done", done, 0);
    chk("arst_out_data", outData, 0);
    chk("arst_out_idx", outIdx, 0);
    q.delete();
    @(posedge clk); #1;
    rstN = 1'b1;
    mode = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_no_out", outValid, 0);
    end
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
